// File: rtl/bankgroup_mc.sv
// rtl/bankgroup_mc.sv - shared SRAM bank group: random access plus NCH FIFO channels (optional sticky errors: BG_MC_ERR_STICKY_EN)
module bankgroup_mc #(
    parameter  int DW  = 32,
    parameter  int AW  = 8,
    parameter  int NCH = 4,
    localparam int DCH = (2 ** AW) / NCH,
    localparam int PW  = (DCH > 1) ? $clog2(DCH) : 1,
    localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           pattern_i,
    input  logic [AW-1:0]  addr_i,
    input  logic [DW-1:0]  din_i,
    input  logic           we_i,
    input  logic           re_i,
    input  logic [SW-1:0]  fifo_sel_i,
    input  logic           flush_i,
    output logic [DW-1:0]  dout_o,
    output logic           dout_vld_o,
    output logic [NCH-1:0] full_o,
    output logic [NCH-1:0] empty_o,
    output logic [NCH-1:0] err_o
);

    logic [DW-1:0] mem [2 ** AW];

    logic [PW-1:0] wr_ptr [NCH];
    logic [PW-1:0] rd_ptr [NCH];
    logic [PW:0]   cnt    [NCH];

    logic [SW-1:0] sel;
    logic          fifo_op;
    logic          rnd_op;
    logic          sel_full;
    logic          sel_empty;
    logic          push;
    logic          pop;
    logic          flush;
    logic [PW:0]   cnt_nxt;
    logic [AW-1:0] base;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          mem_we;
    logic          rd_en;

    // Pointer advance with explicit wrap at the channel depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DCH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode the current request into accepted push/pop, flush and array port controls.
    always_comb begin
        sel       = (NCH > 1) ? fifo_sel_i : '0;
        fifo_op   = en_i & pattern_i;
        rnd_op    = en_i & ~pattern_i;
        sel_full  = full_o[sel];
        sel_empty = empty_o[sel];
        flush     = fifo_op & flush_i;
        // A full channel still takes a push when a pop frees a slot the same cycle.
        push      = fifo_op & ~flush_i & we_i & (~sel_full | re_i);
        // No fall-through: an empty channel never pops, even alongside a push.
        pop       = fifo_op & ~flush_i & re_i & ~sel_empty;
        cnt_nxt   = cnt[sel] + (PW + 1)'(push) - (PW + 1)'(pop);
        base      = AW'(32'(sel) * DCH);
        waddr     = pattern_i ? (base + AW'(wr_ptr[sel])) : addr_i;
        raddr     = pattern_i ? (base + AW'(rd_ptr[sel])) : addr_i;
        mem_we    = (rnd_op & we_i) | push;
        rd_en     = (rnd_op & re_i) | pop;
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr] <= din_i;
        end
    end

    // Registered read: nonblocking read of mem gives read-before-write on same-address collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_o     <= '0;
            dout_vld_o <= 1'b0;
        end else begin
            dout_vld_o <= rd_en;
            if (rd_en) begin
                dout_o <= mem[raddr];
            end
        end
    end

    // Per-channel pointers, occupancy and registered flags; only the selected channel moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            full_o  <= '0;
            empty_o <= '1;
        end else if (fifo_op) begin
            for (int c = 0; c < NCH; c++) begin
                if (sel == SW'(c)) begin
                    if (flush) begin
                        wr_ptr[c]  <= '0;
                        rd_ptr[c]  <= '0;
                        cnt[c]     <= '0;
                        full_o[c]  <= 1'b0;
                        empty_o[c] <= 1'b1;
                    end else begin
                        if (push) begin
                            wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                        end
                        if (pop) begin
                            rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                        end
                        cnt[c]     <= cnt_nxt;
                        full_o[c]  <= (cnt_nxt == (PW + 1)'(DCH));
                        empty_o[c] <= (cnt_nxt == '0);
                    end
                end
            end
        end
    end

`ifdef BG_MC_ERR_STICKY_EN
    logic rej;

    // A push refused for lack of space or a pop refused for lack of data.
    always_comb begin
        rej = fifo_op & ~flush_i & ((we_i & sel_full & ~re_i) | (re_i & sel_empty));
    end

    // Sticky per-channel error, cleared only by reset or a flush of that channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (sel == SW'(c)) begin
                    if (flush) begin
                        err_o[c] <= 1'b0;
                    end else if (rej) begin
                        err_o[c] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign err_o = '0;
`endif

endmodule
